// File: rtl/usb_in_pkt_writer.sv
// usb_in_pkt_writer: feeds a valid/ready/last byte stream into the USB IN
// endpoint buffer. The stream is cut into packets of at most MAX_PKT bytes.
// Each packet is committed and its ack awaited before the next one starts.
// When a transfer ends exactly on a MAX_PKT boundary, a zero-length packet
// follows.
module usb_in_pkt_writer #(
  parameter int unsigned MAX_PKT = 512,
  parameter bit          ZLP_EN  = 1'b1
) (
  input  logic        phy_ulpi_clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        buf_in_ready,
  output logic [8:0]  buf_in_addr,
  output logic [7:0]  buf_in_data,
  output logic        buf_in_wren,
  output logic        buf_in_commit,
  output logic [9:0]  buf_in_commit_len,
  input  logic        buf_in_commit_ack,
  output logic        busy,
  output logic        pkt_done,
  output logic [15:0] pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COMMIT,
    WAIT_ACK
  } state_t;

  localparam logic [9:0] MAX_LEN = 10'(MAX_PKT);

  state_t     state;
  logic [9:0] count;
  logic [9:0] count_nxt;
  logic       zlp_pending;
  logic       pkt_end;

  assign s_ready   = (state == FILL);
  assign busy      = (state != IDLE);
  assign count_nxt = count + 10'd1;
  // A byte closes the packet when it is the last of the transfer or fills MAX_PKT
  assign pkt_end   = s_last || (count_nxt == MAX_LEN);

  // Packet FSM with registered buffer-write, commit and status outputs
  always_ff @(posedge phy_ulpi_clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      count             <= '0;
      zlp_pending       <= 1'b0;
      buf_in_addr       <= '0;
      buf_in_data       <= '0;
      buf_in_wren       <= 1'b0;
      buf_in_commit     <= 1'b0;
      buf_in_commit_len <= '0;
      pkt_done          <= 1'b0;
      pkt_cnt           <= '0;
    end else begin
      buf_in_wren   <= 1'b0;
      buf_in_commit <= 1'b0;
      pkt_done      <= 1'b0;
      case (state)
        IDLE: begin
          // A pending zero-length packet goes out before any new data
          if (buf_in_ready && zlp_pending) begin
            count <= '0;
            state <= COMMIT;
          end else if (buf_in_ready && s_valid) begin
            count <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (s_valid) begin
            buf_in_wren <= 1'b1;
            buf_in_addr <= count[8:0];
            buf_in_data <= s_data;
            count       <= count_nxt;
            if (pkt_end) begin
              state <= COMMIT;
            end
            if (ZLP_EN && s_last && (count_nxt == MAX_LEN)) begin
              zlp_pending <= 1'b1;
            end
          end
        end
        COMMIT: begin
          buf_in_commit     <= 1'b1;
          buf_in_commit_len <= count;
          state             <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // The first WAIT_ACK cycle is the commit-pulse cycle, so an ack
          // coinciding with the pulse is taken here as well.
          if (buf_in_commit_ack) begin
            pkt_done          <= 1'b1;
            pkt_cnt           <= pkt_cnt + 16'd1;
            buf_in_commit_len <= '0;
            if (zlp_pending && (buf_in_commit_len == 10'd0)) begin
              zlp_pending <= 1'b0;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
